// File: rtl/accel_cfg_pkg.sv
// Shared definitions for the accelerator config sequencer: CSR selects,
// command bits, FSM states and CSR field layout.
package accel_cfg_pkg;

    localparam logic [2:0] SEL_MAPPING   = 3'd0;
    localparam logic [2:0] SEL_SHAPE1    = 3'd1;
    localparam logic [2:0] SEL_SHAPE2    = 3'd2;
    localparam logic [2:0] SEL_BIAS_SEL  = 3'd3;
    localparam logic [2:0] SEL_OP_CONFIG = 3'd4;
    localparam logic [2:0] SEL_COMMAND   = 3'd5;

    localparam int unsigned CMD_START_BIT   = 0;
    localparam int unsigned CMD_CLR_ERR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // mapping register layout
    localparam int unsigned MAP_T_LSB  = 0;
    localparam int unsigned MAP_R_LSB  = 3;
    localparam int unsigned MAP_Q_LSB  = 6;
    localparam int unsigned MAP_P_LSB  = 9;
    localparam int unsigned MAP_E_LSB  = 12;
    localparam int unsigned MAP_M_LSB  = 17;
    localparam int unsigned MAP_SML_W  = 3;
    localparam int unsigned MAP_E_W    = 5;
    localparam int unsigned MAP_M_W    = 10;

    // shape1 / shape2 register layout
    localparam int unsigned SH1_M_LSB   = 0;
    localparam int unsigned SH1_C_LSB   = 10;
    localparam int unsigned SH1_S_LSB   = 20;
    localparam int unsigned SH1_R_LSB   = 22;
    localparam int unsigned SH1_U_LSB   = 24;
    localparam int unsigned SH1_PAD_LSB = 26;
    localparam int unsigned SH1_SML_W   = 2;
    localparam int unsigned SH2_H_LSB   = 0;
    localparam int unsigned SH2_W_LSB   = 8;
    localparam int unsigned SH2_W_W     = 8;

    // Fields consumed by the base-address datapath
    typedef struct packed {
        logic [MAP_SML_W-1:0] map_t;
        logic [MAP_SML_W-1:0] map_r;
        logic [MAP_SML_W-1:0] map_q;
        logic [MAP_SML_W-1:0] map_p;
        logic [MAP_E_W-1:0]   map_e;
        logic [SH1_SML_W-1:0] shp_u;
        logic [SH1_SML_W-1:0] shp_r;
        logic [SH1_SML_W-1:0] shp_s;
        logic [SH2_W_W-1:0]   shp_w;
    } calc_fields_t;

    function automatic calc_fields_t decode_fields(input logic [31:0] mapping,
                                                   input logic [31:0] shape1,
                                                   input logic [31:0] shape2);
        calc_fields_t f;
        f.map_t = mapping[MAP_T_LSB +: MAP_SML_W];
        f.map_r = mapping[MAP_R_LSB +: MAP_SML_W];
        f.map_q = mapping[MAP_Q_LSB +: MAP_SML_W];
        f.map_p = mapping[MAP_P_LSB +: MAP_SML_W];
        f.map_e = mapping[MAP_E_LSB +: MAP_E_W];
        f.shp_u = shape1[SH1_U_LSB +: SH1_SML_W];
        f.shp_r = shape1[SH1_R_LSB +: SH1_SML_W];
        f.shp_s = shape1[SH1_S_LSB +: SH1_SML_W];
        f.shp_w = shape2[SH2_W_LSB +: SH2_W_W];
        return f;
    endfunction

endpackage

// File: rtl/accel_cfg_sequencer_base_addr_calc.sv
// Six-stage fixed-latency GLB base-address datapath. Fields must stay
// stable from start until the results are captured (active bank is frozen
// while the sequencer is in CALC). valid_c is high in the cycle whose
// closing edge captures the results.
module base_addr_calc
    import accel_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  calc_fields_t      fields,
    output logic              valid_c,
    output logic [ADDR_W-1:0] filter_base,
    output logic [ADDR_W-1:0] bias_base,
    output logic [ADDR_W-1:0] opsum_base
);

    logic [5:0]          vld;
    logic [MAP_E_W-1:0]  e_sat;
    logic [ADDR_W-1:0]   s1_h, s1_qr, s1_pt;
    logic [ADDR_W-1:0]   s2_f1, s2_rs;
    logic [ADDR_W-1:0]   s3_filter, s3_b1;
    logic [ADDR_W-1:0]   s4_b2;
    logic [ADDR_W-1:0]   s5_bias;

    // e-1 saturating at zero
    assign e_sat   = (fields.map_e == '0) ? '0 : fields.map_e - MAP_E_W'(1);
    assign valid_c = vld[4];

    // Stage registers, each loaded only when its stage is active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld         <= '0;
            s1_h        <= '0;
            s1_qr       <= '0;
            s1_pt       <= '0;
            s2_f1       <= '0;
            s2_rs       <= '0;
            s3_filter   <= '0;
            s3_b1       <= '0;
            s4_b2       <= '0;
            s5_bias     <= '0;
            filter_base <= '0;
            bias_base   <= '0;
            opsum_base  <= '0;
        end else begin
            vld <= {vld[4:0], start};
            if (start) begin
                s1_h  <= ADDR_W'(fields.shp_u) * ADDR_W'(e_sat) + ADDR_W'(fields.shp_r);
                s1_qr <= ADDR_W'(fields.map_q) * ADDR_W'(fields.map_r);
                s1_pt <= ADDR_W'(fields.map_p) * ADDR_W'(fields.map_t);
            end
            if (vld[0]) begin
                s2_f1 <= s1_qr * s1_h;
                s2_rs <= ADDR_W'(fields.shp_r) * ADDR_W'(fields.shp_s);
            end
            if (vld[1]) begin
                s3_filter <= s2_f1 * ADDR_W'(fields.shp_w);
                s3_b1     <= s1_pt * s1_qr;
            end
            if (vld[2]) begin
                s4_b2 <= s3_b1 * s2_rs;
            end
            if (vld[3]) begin
                s5_bias <= s3_filter + s4_b2;
            end
            if (vld[4]) begin
                filter_base <= s3_filter;
                bias_base   <= s5_bias;
                opsum_base  <= s5_bias + (s1_pt << 2);
            end
        end
    end

endmodule

// File: rtl/accel_cfg_sequencer.sv
// Accelerator config sequencer: shadow/active CSR banks, base-address
// datapath, launch FSM and GLB ownership mux.
// Optional macro PERF_CNT_EN adds the run_cycles counter output.
module accel_cfg_sequencer
    import accel_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_wen,
    input  logic [2:0]        csr_wsel,
    input  logic [DATA_W-1:0] csr_wdata,
    input  logic [WE_W-1:0]   host_we,
    input  logic [WE_W-1:0]   host_re,
    input  logic [ADDR_W-1:0] host_w_addr,
    input  logic [ADDR_W-1:0] host_r_addr,
    input  logic [DATA_W-1:0] host_w_data,
    output logic [DATA_W-1:0] host_r_data,
    input  logic [WE_W-1:0]   ctrl_we,
    input  logic [WE_W-1:0]   ctrl_re,
    input  logic [ADDR_W-1:0] ctrl_w_addr,
    input  logic [ADDR_W-1:0] ctrl_r_addr,
    input  logic [DATA_W-1:0] ctrl_w_data,
    output logic [DATA_W-1:0] ctrl_r_data,
    output logic [WE_W-1:0]   glb_we,
    output logic [WE_W-1:0]   glb_re,
    output logic [ADDR_W-1:0] glb_w_addr,
    output logic [ADDR_W-1:0] glb_r_addr,
    output logic [DATA_W-1:0] glb_w_data,
    input  logic [DATA_W-1:0] glb_r_data,
    output logic [31:0]       act_op_config,
    output logic [31:0]       act_mapping,
    output logic [31:0]       act_shape1,
    output logic [31:0]       act_shape2,
    output logic              act_bias_ipsum_sel,
    output logic [ADDR_W-1:0] filter_base,
    output logic [ADDR_W-1:0] bias_base,
    output logic [ADDR_W-1:0] opsum_base,
    output logic [ADDR_W-1:0] ifmap_base,
    output logic              ctrl_start,
    input  logic              ctrl_done,
    output logic              busy,
    output logic              done,
    output logic              host_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       run_cycles
`endif
);

    state_t      state, state_nxt;
    logic        start_q;
    logic        err_clr;
    logic        pending, pending_nxt;
    logic        err_set, host_err_nxt;
    logic        load_active;
    logic        calc_go;
    logic        calc_valid_c;
    logic        ctrl_owns;
    logic        ctrl_start_nxt, done_nxt, busy_nxt;
    logic [31:0] sh_op_config, sh_mapping, sh_shape1, sh_shape2;
    logic        sh_bias_sel;

    assign ifmap_base = '0;
    assign ctrl_owns  = (state == ST_CALC) || (state == ST_RUN);
    assign err_clr    = csr_wen && (csr_wsel == SEL_COMMAND) && csr_wdata[CMD_CLR_ERR_BIT];

    // Shadow bank and registered start command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_op_config <= '0;
            sh_mapping   <= '0;
            sh_shape1    <= '0;
            sh_shape2    <= '0;
            sh_bias_sel  <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            start_q <= csr_wen && (csr_wsel == SEL_COMMAND) && csr_wdata[CMD_START_BIT];
            if (csr_wen) begin
                case (csr_wsel)
                    SEL_MAPPING:   sh_mapping   <= 32'(csr_wdata);
                    SEL_SHAPE1:    sh_shape1    <= 32'(csr_wdata);
                    SEL_SHAPE2:    sh_shape2    <= 32'(csr_wdata);
                    SEL_BIAS_SEL:  sh_bias_sel  <= csr_wdata[0];
                    SEL_OP_CONFIG: sh_op_config <= 32'(csr_wdata);
                    default:       ;
                endcase
            end
        end
    end

    // Active bank, snapshot of the shadow bank at each launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_op_config      <= '0;
            act_mapping        <= '0;
            act_shape1         <= '0;
            act_shape2         <= '0;
            act_bias_ipsum_sel <= 1'b0;
        end else if (load_active) begin
            act_op_config      <= sh_op_config;
            act_mapping        <= sh_mapping;
            act_shape1         <= sh_shape1;
            act_shape2         <= sh_shape2;
            act_bias_ipsum_sel <= sh_bias_sel;
        end
    end

    base_addr_calc #(.ADDR_W(ADDR_W)) u_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (calc_go),
        .fields      (decode_fields(act_mapping, act_shape1, act_shape2)),
        .valid_c     (calc_valid_c),
        .filter_base (filter_base),
        .bias_base   (bias_base),
        .opsum_base  (opsum_base)
    );

    // Launch FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            host_err   <= 1'b0;
            calc_go    <= 1'b0;
            ctrl_start <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            host_err   <= host_err_nxt;
            calc_go    <= load_active;
            ctrl_start <= ctrl_start_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
        end
    end

    // Launch FSM next state; a start while busy is queued, a second one is an error
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        err_set     = 1'b0;
        load_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_q) begin
                    state_nxt   = ST_CALC;
                    load_active = 1'b1;
                end
            end
            ST_CALC, ST_RUN: begin
                if (state == ST_CALC && calc_valid_c) begin
                    state_nxt = ST_RUN;
                end
                if (state == ST_RUN && ctrl_done) begin
                    state_nxt = ST_DONE;
                end
                if (start_q) begin
                    if (pending) err_set = 1'b1;
                    else         pending_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_q && pending) begin
                    err_set = 1'b1;
                end
                if (start_q || pending) begin
                    state_nxt   = ST_CALC;
                    load_active = 1'b1;
                    pending_nxt = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (ctrl_owns && ((host_we != '0) || (host_re != '0))) begin
            err_set = 1'b1;
        end
        host_err_nxt   = err_set ? 1'b1 : (err_clr ? 1'b0 : host_err);
        ctrl_start_nxt = (state == ST_CALC) && (state_nxt == ST_RUN);
        done_nxt       = (state_nxt == ST_DONE);
        busy_nxt       = (state_nxt == ST_CALC) || (state_nxt == ST_RUN);
    end

    // GLB ownership mux, decoded from the registered state
    always_comb begin
        glb_we      = ctrl_owns ? ctrl_we     : host_we;
        glb_re      = ctrl_owns ? ctrl_re     : host_re;
        glb_w_addr  = ctrl_owns ? ctrl_w_addr : host_w_addr;
        glb_r_addr  = ctrl_owns ? ctrl_r_addr : host_r_addr;
        glb_w_data  = ctrl_owns ? ctrl_w_data : host_w_data;
        host_r_data = glb_r_data;
        ctrl_r_data = glb_r_data;
    end

`ifdef PERF_CNT_EN
    // Saturating CALC+RUN cycle counter, cleared at each launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles <= '0;
        end else if (load_active) begin
            run_cycles <= '0;
        end else if (ctrl_owns && (run_cycles != 32'hFFFF_FFFF)) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end
`endif

endmodule
